// File: rtl/riscv_pkg.sv
// Shared RV32I constants and store-lane helpers for the memory pipeline stage.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {IDLE, WAIT} mem_state_t;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_SB:   store_be = 4'b0001 << a;
            F3_SH:   store_be = 4'b0011 << a;
            F3_SW:   store_be = 4'hF;
            default: store_be = 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_SB:   store_wdata = {4{d[7:0]}};
            F3_SH:   store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a loaded word and extends it to 32 bits.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*addr_lo +: 8];
        half_sel = rdata[16*addr_lo[1] +: 16];
        case (func3)
            F3_LB:   result = 32'(byte_sel);
            F3_LH:   result = 32'(half_sel);
            F3_LW:   result = rdata;
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues RV32I loads/stores over a req/ack port and retires {instr, result}.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              ex_valid,
    input  logic [95:0]       ex_reg,
    output logic              ex_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic [63:0]       wb_reg,
    output logic              wb_valid,
    output logic              misaligned
);

    mem_state_t state_q, state_d;

    logic [31:0]       instr, alu, sdata;
    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic              is_load, is_store, is_mem, mis_acc, accept;
    logic [ADDR_W-1:0] addr_full;

    logic [31:0] instr_p1;
    logic [1:0]  alo_p1;
    logic [2:0]  f3_p1;
    logic        load_p1;
    logic [31:0] load_res;

    assign instr     = ex_reg[95:64];
    assign alu       = ex_reg[63:32];
    assign sdata     = ex_reg[31:0];
    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_mem    = is_load || is_store;
    assign addr_full = ADDR_W'(alu);

    // Only half and word accesses can be misaligned; unknown func3 encodings never flag.
    always_comb begin
        mis_acc = 1'b0;
        if (is_load) begin
            case (f3)
                F3_LH, F3_LHU: mis_acc = alu[0];
                F3_LW:         mis_acc = |alu[1:0];
                default:       mis_acc = 1'b0;
            endcase
        end else if (is_store) begin
            case (f3)
                F3_SH:   mis_acc = alu[0];
                F3_SW:   mis_acc = |alu[1:0];
                default: mis_acc = 1'b0;
            endcase
        end
    end

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid && ex_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_mem && !mis_acc) state_d = WAIT;
            WAIT:    if (dmem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (alo_p1),
        .func3   (f3_p1),
        .result  (load_res)
    );

    // p1: request issue on accept, retirement on accept (pass/misaligned) or on ack
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'd0;
            wb_reg     <= 64'd0;
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            instr_p1   <= 32'd0;
            alo_p1     <= 2'd0;
            f3_p1      <= 3'd0;
            load_p1    <= 1'b0;
        end else begin
            wb_reg     <= 64'd0;
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            if (state_q == IDLE) begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_reg   <= {instr, alu};
                        wb_valid <= 1'b1;
                    end else if (mis_acc) begin
                        wb_reg     <= {instr, 32'd0};
                        wb_valid   <= 1'b1;
                        misaligned <= 1'b1;
                    end else begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= addr_full & ~ADDR_W'(3);
                        dmem_be    <= is_store ? store_be(f3, alu[1:0]) : 4'hF;
                        dmem_wdata <= is_store ? store_wdata(f3, sdata) : 32'd0;
                        instr_p1   <= instr;
                        alo_p1     <= alu[1:0];
                        f3_p1      <= f3;
                        load_p1    <= is_load;
                    end
                end
            end else if (dmem_ack) begin
                dmem_req <= 1'b0;
                wb_reg   <= {instr_p1, load_p1 ? load_res : 32'd0};
                wb_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with a retirement scoreboard plus corner sequences.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        ex_valid;
    logic [95:0] ex_reg;
    logic        ex_ready;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic [63:0] wb_reg;
    logic        wb_valid, misaligned;

    mem_stage #(.ADDR_W(32)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .ex_valid(ex_valid), .ex_reg(ex_reg),
        .ex_ready(ex_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_reg(wb_reg),
        .wb_valid(wb_valid), .misaligned(misaligned)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr, alu, sdata, rdata;
        int          delay;
        logic        mem;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata, res;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [63:0] wb;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd1, op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (wb_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_retire", {32'd0, wb_reg[63:32]}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("wb_reg", wb_reg, e.wb);
                    chk("misaligned", {63'd0, misaligned}, {63'd0, e.mis});
                end
            end else begin
                chk("bubble_wb_reg", wb_reg, 64'd0);
                chk("bubble_misaligned", {63'd0, misaligned}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_vec(input vec_t v);
        exp_t e;
        @(posedge i_clk); #1;
        ex_valid = 1'b1;
        ex_reg   = {v.instr, v.alu, v.sdata};
        chk("ex_ready_idle", {63'd0, ex_ready}, 64'd1);
        e.wb  = {v.instr, v.res};
        e.mis = v.mis;
        sb_q.push_back(e);
        @(posedge i_clk); #1;
        ex_valid = 1'b0;
        if (v.mem) begin
            chk("dmem_req", {63'd0, dmem_req}, 64'd1);
            chk("dmem_we", {63'd0, dmem_we}, {63'd0, v.we});
            chk("dmem_addr", {32'd0, dmem_addr}, {32'd0, v.alu & ~32'd3});
            if (v.we) begin
                chk("dmem_be", {60'd0, dmem_be}, {60'd0, v.be});
                chk("dmem_wdata", {32'd0, dmem_wdata}, {32'd0, v.wdata});
            end
            for (int i = 0; i < v.delay - 1; i++) begin
                chk("ex_ready_wait", {63'd0, ex_ready}, 64'd0);
                @(posedge i_clk); #1;
                chk("req_held", {63'd0, dmem_req}, 64'd1);
            end
            chk("ex_ready_wait", {63'd0, ex_ready}, 64'd0);
            dmem_ack   = 1'b1;
            dmem_rdata = v.rdata;
            @(posedge i_clk); #1;
            dmem_ack   = 1'b0;
            dmem_rdata = 32'h5A5A5A5A;
            chk("req_dropped", {63'd0, dmem_req}, 64'd0);
            chk("ex_ready_back", {63'd0, ex_ready}, 64'd1);
        end else begin
            chk("no_req", {63'd0, dmem_req}, 64'd0);
        end
    endtask

    initial begin
        vec_t       vt[$];
        vec_t       v;
        logic [7:0] exp_b[4];

        vt.push_back('{32'h003100B3, 32'h1234, 32'h0, 32'h0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h1234, 1'b0});
        vt.push_back('{mk(OP_STORE, F3_SB), 32'h103, 32'hAB, 32'h0, 3, 1'b1, 1'b1, 4'b1000, 32'hABABABAB, 32'h0, 1'b0});
        vt.push_back('{mk(OP_LOAD, F3_LB), 32'h102, 32'h0, 32'h00F00000, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFFFFF0, 1'b0});
        vt.push_back('{mk(OP_LOAD, F3_LBU), 32'h102, 32'h0, 32'h00F00000, 2, 1'b1, 1'b0, 4'h0, 32'h0, 32'h000000F0, 1'b0});
        vt.push_back('{mk(OP_LOAD, F3_LW), 32'h102, 32'h0, 32'h0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1});
        vt.push_back('{mk(OP_LOAD, F3_LH), 32'h102, 32'h0, 32'h80010000, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF8001, 1'b0});
        vt.push_back('{mk(OP_LOAD, F3_LHU), 32'h102, 32'h0, 32'h80010000, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h00008001, 1'b0});
        vt.push_back('{mk(OP_LOAD, F3_LW), 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b1, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0});
        vt.push_back('{mk(OP_STORE, F3_SH), 32'h102, 32'h12345678, 32'h0, 1, 1'b1, 1'b1, 4'b1100, 32'h56785678, 32'h0, 1'b0});
        vt.push_back('{mk(OP_STORE, F3_SW), 32'h104, 32'hCAFEF00D, 32'h0, 2, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0});
        vt.push_back('{mk(OP_STORE, F3_SH), 32'h101, 32'h1111, 32'h0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1});
        vt.push_back('{mk(OP_LOAD, F3_LB), 32'h101, 32'h0, 32'h00007F00, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0000007F, 1'b0});
        vt.push_back('{mk(OP_LOAD, 3'b011), 32'h100, 32'h0, 32'hFFFFFFFF, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0});
        vt.push_back('{mk(OP_LOAD, F3_LHU), 32'h101, 32'h0, 32'h0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1});
        vt.push_back('{mk(OP_STORE, F3_SB), 32'h200, 32'h7E, 32'h0, 1, 1'b1, 1'b1, 4'b0001, 32'h7E7E7E7E, 32'h0, 1'b0});

        i_rstn     = 1'b0;
        ex_valid   = 1'b0;
        ex_reg     = 96'd0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        @(posedge i_clk); #1;
        mon_en = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_we", {63'd0, dmem_we}, 64'd0);
        chk("rst_addr", {32'd0, dmem_addr}, 64'd0);
        chk("rst_be", {60'd0, dmem_be}, 64'd0);
        chk("rst_wdata", {32'd0, dmem_wdata}, 64'd0);
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        i_rstn = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_ex_ready", {63'd0, ex_ready}, 64'd1);

        foreach (vt[i]) do_vec(vt[i]);

        // Reset in WAIT abandons the access; the following ack lands in IDLE.
        @(posedge i_clk); #1;
        ex_valid = 1'b1;
        ex_reg   = {mk(OP_LOAD, F3_LW), 32'h200, 32'h0};
        @(posedge i_clk); #1;
        ex_valid = 1'b0;
        chk("rstwait_req_on", {63'd0, dmem_req}, 64'd1);
        i_rstn = 1'b0;
        @(posedge i_clk); #1;
        i_rstn     = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        chk("rstwait_req_off", {63'd0, dmem_req}, 64'd0);
        chk("rstwait_ex_ready", {63'd0, ex_ready}, 64'd1);
        chk("rstwait_addr", {32'd0, dmem_addr}, 64'd0);
        @(posedge i_clk); #1;
        dmem_ack = 1'b0;
        chk("rstwait_no_retire", {63'd0, wb_valid}, 64'd0);
        chk("rstwait_req_stays", {63'd0, dmem_req}, 64'd0);

        // Ack held high with back-to-back byte loads.
        exp_b[0] = 8'hBB; exp_b[1] = 8'hAA; exp_b[2] = 8'h99; exp_b[3] = 8'h88;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h8899AABB;
        @(posedge i_clk); #1;
        chk("idle_ack_ignored", {63'd0, wb_valid}, 64'd0);
        ex_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            ex_reg = {mk(OP_LOAD, F3_LBU), 32'h300 + 32'(i), 32'h0};
            e.wb   = {mk(OP_LOAD, F3_LBU), 24'd0, exp_b[i]};
            e.mis  = 1'b0;
            sb_q.push_back(e);
            chk("b2b_ready", {63'd0, ex_ready}, 64'd1);
            @(posedge i_clk); #1;
            chk("b2b_busy", {63'd0, ex_ready}, 64'd0);
            chk("b2b_req", {63'd0, dmem_req}, 64'd1);
            chk("b2b_no_retire", {63'd0, wb_valid}, 64'd0);
            @(posedge i_clk); #1;
            chk("b2b_retire", {63'd0, wb_valid}, 64'd1);
            chk("b2b_req_low", {63'd0, dmem_req}, 64'd0);
        end
        ex_valid = 1'b0;
        dmem_ack = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
